// File: rtl/rr_encoder_arbiter.sv
// rr_encoder_arbiter
//   Four-requester round-robin arbiter with sticky grants and an encoded
//   grant index for a shared downstream consumer.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     When defined, an owner that has held the grant for MAX_HOLD cycles is
//     preempted if another requester is waiting. When undefined, grants are
//     held until release and preempt is tied low.
//
//   Ports
//     clk          system clock, rising edge
//     rst          synchronous active-high reset
//     req[3:0]     request vector, bit i = requester i
//     grant[3:0]   registered one-hot grant, zero when idle
//     grant_idx    binary index of the granted requester, 0 when idle
//     grant_valid  high while any grant is held
//     preempt      one-cycle pulse after a timeout revocation
module rr_encoder_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [1:0] last_ptr;

  // Returns {found, index} of the first set bit of r, scanning upward from
  // start with wrap-around.
  function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    // Scan from the farthest offset down so the nearest hit wins.
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [3:0] others;
  logic [2:0] pick_idle;
  logic [2:0] pick_rot;
  logic       do_issue;
  logic [1:0] issue_idx;
  logic       do_drop;
  logic       do_revoke;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_max;
  assign hold_max = (hold_cnt == HOLD_W'(MAX_HOLD));
`endif

  assign others    = req & ~grant;
  assign pick_idle = rr_pick(req, last_ptr + 2'd1);
  assign pick_rot  = rr_pick(others, grant_idx + 2'd1);

  always_comb begin
    do_issue  = 1'b0;
    issue_idx = 2'd0;
    do_drop   = 1'b0;
    do_revoke = 1'b0;
    case (state)
      IDLE: begin
        if (pick_idle[2]) begin
          do_issue  = 1'b1;
          issue_idx = pick_idle[1:0];
        end
      end
      BUSY: begin
        if (!req[grant_idx]) begin
          // Owner released: hand off at the same edge if anyone is waiting.
          if (pick_rot[2]) begin
            do_issue  = 1'b1;
            issue_idx = pick_rot[1:0];
          end else begin
            do_drop = 1'b1;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_max && pick_rot[2]) begin
          do_issue  = 1'b1;
          issue_idx = pick_rot[1:0];
          do_revoke = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 4'b0000;
      grant_idx   <= 2'd0;
      grant_valid <= 1'b0;
      last_ptr    <= 2'd3;
`ifdef ARB_TIMEOUT_EN
      hold_cnt    <= '0;
      preempt     <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      preempt <= do_revoke;
`endif
      if (do_issue) begin
        state       <= BUSY;
        grant       <= 4'b0001 << issue_idx;
        grant_idx   <= issue_idx;
        grant_valid <= 1'b1;
        last_ptr    <= issue_idx;
`ifdef ARB_TIMEOUT_EN
        hold_cnt    <= '0;
`endif
      end else if (do_drop) begin
        state       <= IDLE;
        grant       <= 4'b0000;
        grant_idx   <= 2'd0;
        grant_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_cnt    <= '0;
`endif
      end
`ifdef ARB_TIMEOUT_EN
      else if (state == BUSY && !hold_max) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
`endif
    end
  end

`ifndef ARB_TIMEOUT_EN
  assign preempt = 1'b0;
  logic unused_revoke;
  assign unused_revoke = do_revoke;
`endif

endmodule
